// File: rtl/fft_seq_ctrl.sv
// Sequencing controller for the 8-point radix-2 DIT FFT core: counter handshake, butterfly
// address/twiddle decode, inter-stage stalls and write-back delay line.
module fft_seq_ctrl #(
  parameter int N_POINTS = 8,
  parameter int STAGES   = 3,
  parameter int BF_LAT   = 2,
  parameter int CNT_W    = 6
) (
  input  logic              Clk,
  input  logic              RSTn,
  input  logic              Start,
  input  logic [CNT_W-1:0]  Cnt_Q,
  input  logic              Cnt_Low,
  output logic              Cnt_Load,
  output logic [CNT_W-1:0]  Cnt_In,
  output logic              Cnt_Down,
  output logic              Busy,
  output logic              Done,
  output logic [1:0]        Stage,
  output logic              Rd_En,
  output logic [STAGES-1:0] Rd_Addr_A,
  output logic [STAGES-1:0] Rd_Addr_B,
  output logic [STAGES-2:0] Tw_Addr,
  output logic              Wr_En,
  output logic [STAGES-1:0] Wr_Addr_A,
  output logic [STAGES-1:0] Wr_Addr_B
);

  localparam int HALF   = N_POINTS / 2;
  localparam int HALF_W = STAGES - 1;
  localparam int TOTAL  = STAGES * HALF;
  localparam int ADDR_W = STAGES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state, w_state_next;
  logic [2:0]        r_wait, w_wait_next;
  logic              w_issue;
  logic [CNT_W-1:0]  w_k, w_s;
  logic [HALF_W-1:0] w_b, w_low, w_tw;
  logic [ADDR_W-1:0] w_addr_a, w_addr_b;
  logic              w_stage_end;
  logic              w_last_op;

  logic              r_wr_en_pipe [BF_LAT];
  logic [ADDR_W-1:0] r_wr_a_pipe  [BF_LAT];
  logic [ADDR_W-1:0] r_wr_b_pipe  [BF_LAT];

  // Remaining count -> op index k, stage s = k / (N/2), butterfly b = k % (N/2).
  assign w_k = CNT_W'(TOTAL) - Cnt_Q;
  assign w_s = w_k >> HALF_W;
  assign w_b = w_k[HALF_W-1:0];

  always_comb begin
    w_low    = w_b & HALF_W'((32'd1 << w_s) - 32'd1);
    w_addr_a = ADDR_W'(((32'(w_b) >> w_s) << (w_s + 32'd1)) + 32'(w_low));
    w_addr_b = w_addr_a + ADDR_W'(32'd1 << w_s);
    w_tw     = HALF_W'(32'(w_low) << (32'(HALF_W) - 32'(w_s)));
  end

  assign w_stage_end = (w_b == HALF_W'(HALF - 1)) && (w_s < CNT_W'(STAGES - 1));
  assign w_last_op   = (Cnt_Q == CNT_W'(1));

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait;
    w_issue      = 1'b0;
    Cnt_Load     = 1'b0;
    Cnt_In       = '0;
    Done         = 1'b0;
    Busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (Start) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        Cnt_Load     = 1'b1;
        Cnt_In       = CNT_W'(TOTAL);
        w_wait_next  = '0;
        w_state_next = S_RUN;
      end
      S_RUN: begin
        if (Cnt_Low) begin
          w_state_next = S_DRAIN;
          w_wait_next  = 3'(BF_LAT - 1);
        end else if (r_wait != 3'd0) begin
          w_wait_next = r_wait - 3'd1;
        end else begin
          w_issue = 1'b1;
          // The final issue heads straight to DRAIN so Done lands the cycle after its write.
          if (w_last_op) begin
            w_state_next = S_DRAIN;
            w_wait_next  = 3'(BF_LAT - 1);
          end else if (w_stage_end) begin
            w_wait_next = 3'(BF_LAT);
          end
        end
      end
      S_DRAIN: begin
        if (r_wait == 3'd0) w_state_next = S_DONE;
        else                w_wait_next  = r_wait - 3'd1;
      end
      S_DONE: begin
        Done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
    end
  end

  assign Rd_En     = w_issue;
  assign Cnt_Down  = w_issue;
  assign Rd_Addr_A = w_issue ? w_addr_a : '0;
  assign Rd_Addr_B = w_issue ? w_addr_b : '0;
  assign Tw_Addr   = w_issue ? w_tw : '0;
  assign Stage     = w_issue ? 2'(w_s) : 2'd0;

  // Write-back mirrors the issue stream BF_LAT cycles later; it keeps shifting through DRAIN.
  always_ff @(posedge Clk or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < BF_LAT; i++) begin
        r_wr_en_pipe[i] <= 1'b0;
        r_wr_a_pipe[i]  <= '0;
        r_wr_b_pipe[i]  <= '0;
      end
    end else begin
      r_wr_en_pipe[0] <= w_issue;
      r_wr_a_pipe[0]  <= Rd_Addr_A;
      r_wr_b_pipe[0]  <= Rd_Addr_B;
      for (int i = 1; i < BF_LAT; i++) begin
        r_wr_en_pipe[i] <= r_wr_en_pipe[i-1];
        r_wr_a_pipe[i]  <= r_wr_a_pipe[i-1];
        r_wr_b_pipe[i]  <= r_wr_b_pipe[i-1];
      end
    end
  end

  assign Wr_En     = r_wr_en_pipe[BF_LAT-1];
  assign Wr_Addr_A = r_wr_a_pipe[BF_LAT-1];
  assign Wr_Addr_B = r_wr_b_pipe[BF_LAT-1];

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Bench for fft_seq_ctrl: BF_LAT=2 and BF_LAT=1 builds side by side, each with its own down
// counter, checked every cycle against a run-schedule model of the FFT sequencing.
module tb_fft_seq_ctrl;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic start = 1'b0;
  logic fault = 1'b0;

  logic       cnt_load [2];
  logic       cnt_down [2];
  logic       busy     [2];
  logic       done     [2];
  logic       rd_en    [2];
  logic       wr_en    [2];
  logic       cnt_low  [2];
  logic [5:0] cnt_in   [2];
  logic [5:0] cnt_q    [2] = '{6'd0, 6'd0};
  logic [1:0] stage    [2];
  logic [1:0] tw       [2];
  logic [2:0] ra       [2];
  logic [2:0] rb       [2];
  logic [2:0] wa       [2];
  logic [2:0] wb       [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  bit m_active [2] = '{1'b0, 1'b0};
  int m_t      [2] = '{0, 0};
  bit m_flt    [2] = '{1'b0, 1'b0};
  int done_q   [2][$];

  logic [27:0] got_v, exp_v;

  always #5 clk = ~clk;

  fft_seq_ctrl #(.BF_LAT(2)) u_dut_lat2 (
    .Clk(clk), .RSTn(rstn), .Start(start), .Cnt_Q(cnt_q[0]), .Cnt_Low(cnt_low[0]),
    .Cnt_Load(cnt_load[0]), .Cnt_In(cnt_in[0]), .Cnt_Down(cnt_down[0]), .Busy(busy[0]),
    .Done(done[0]), .Stage(stage[0]), .Rd_En(rd_en[0]), .Rd_Addr_A(ra[0]), .Rd_Addr_B(rb[0]),
    .Tw_Addr(tw[0]), .Wr_En(wr_en[0]), .Wr_Addr_A(wa[0]), .Wr_Addr_B(wb[0])
  );

  fft_seq_ctrl #(.BF_LAT(1)) u_dut_lat1 (
    .Clk(clk), .RSTn(rstn), .Start(start), .Cnt_Q(cnt_q[1]), .Cnt_Low(cnt_low[1]),
    .Cnt_Load(cnt_load[1]), .Cnt_In(cnt_in[1]), .Cnt_Down(cnt_down[1]), .Busy(busy[1]),
    .Done(done[1]), .Stage(stage[1]), .Rd_En(rd_en[1]), .Rd_Addr_A(ra[1]), .Rd_Addr_B(rb[1]),
    .Tw_Addr(tw[1]), .Wr_En(wr_en[1]), .Wr_Addr_A(wa[1]), .Wr_Addr_B(wb[1])
  );

  // External 6-bit down counter; fault forces its zero flag high.
  assign cnt_low[0] = fault | (cnt_q[0] == 6'd0);
  assign cnt_low[1] = fault | (cnt_q[1] == 6'd0);

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cnt_load[i])      cnt_q[i] <= cnt_in[i];
      else if (cnt_down[i]) cnt_q[i] <= cnt_q[i] - 6'd1;
    end
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Cycle (relative to the Start-seen cycle) at which op k issues: each finished stage adds L idle cycles.
  function automatic int issue_time(input int k, input int lat);
    return 2 + k + lat * (k / 4);
  endfunction

  function automatic int run_len(input int lat, input bit flt);
    return flt ? (lat + 3) : (2 + 12 + 3 * lat);
  endfunction

  function automatic bit find_op(input int t, input int lat, output int k);
    k = 0;
    for (int kk = 0; kk < 12; kk++) begin
      if (issue_time(kk, lat) == t) begin
        k = kk;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Stage s pairs index i (bit s clear) with i+span, in ascending i; twiddle is (i mod span)*(N/2/span).
  function automatic void butterfly(input int k, output int a, output int b, output int t);
    int s, bi, span, n;
    s = k / 4; bi = k % 4; span = 1 << s; n = 0;
    a = 0; b = 0; t = 0;
    for (int i = 0; i < 8; i++) begin
      if ((i & span) == 0) begin
        if (n == bi) begin
          a = i; b = i + span; t = (i % span) * (4 / span);
        end
        n++;
      end
    end
  endfunction

  function automatic logic [27:0] model_out(input bit act, input int t, input int lat, input bit flt);
    int k, a, b, tv;
    logic rd, wr;
    logic [1:0] st, twv;
    logic [2:0] ra_e, rb_e, wa_e, wb_e;
    rd = 1'b0; wr = 1'b0; st = '0; twv = '0;
    ra_e = '0; rb_e = '0; wa_e = '0; wb_e = '0;
    if (!act) return '0;
    if (!flt && find_op(t, lat, k)) begin
      butterfly(k, a, b, tv);
      rd = 1'b1; st = 2'(k / 4); ra_e = 3'(a); rb_e = 3'(b); twv = 2'(tv);
    end
    if (!flt && find_op(t - lat, lat, k)) begin
      butterfly(k, a, b, tv);
      wr = 1'b1; wa_e = 3'(a); wb_e = 3'(b);
    end
    return {(t == 1), ((t == 1) ? 6'd12 : 6'd0), rd, 1'b1, (t == run_len(lat, flt)),
            st, rd, ra_e, rb_e, twv, wr, wa_e, wb_e};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_done(input int i, input int c0, input int n, input int o0, input int o1);
    chk($sformatf("done count inst%0d", i), done_q[i].size(), n);
    chk($sformatf("first Done offset inst%0d", i), (done_q[i].size() > 0) ? done_q[i][0] - c0 : -1, o0);
    if (n > 1)
      chk($sformatf("second Done offset inst%0d", i), (done_q[i].size() > 1) ? done_q[i][1] - c0 : -1, o1);
  endtask

  // Model advance: Start is taken only while idle; the run ends the cycle after Done.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        m_active[i] = 1'b0;
      end else if (m_active[i]) begin
        m_t[i]++;
        if (m_t[i] > run_len(lat_of(i), m_flt[i])) m_active[i] = 1'b0;
      end else if (start) begin
        m_active[i] = 1'b1;
        m_t[i]      = 1;
        m_flt[i]    = fault;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      got_v = {cnt_load[i], cnt_in[i], cnt_down[i], busy[i], done[i], stage[i], rd_en[i],
               ra[i], rb[i], tw[i], wr_en[i], wa[i], wb[i]};
      exp_v = rstn ? model_out(m_active[i], m_t[i], lat_of(i), m_flt[i]) : '0;
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL outputs inst%0d cyc=%0d t=%0d: got %h, expected %h",
                 i, cyc, m_t[i], got_v, exp_v);
      end
      if (done[i] === 1'b1) begin
        done_q[i].push_back(cyc);
        $display("run complete: inst%0d (BF_LAT=%0d) Done at cycle %0d", i, lat_of(i), cyc);
      end
    end
  end

  initial begin
    int c0;
    int lit_a [12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_b [12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int lit_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int lit_rd2 [12] = '{2, 3, 4, 5, 8, 9, 10, 11, 14, 15, 16, 17};
    int lit_rd1 [12] = '{2, 3, 4, 5, 7, 8, 9, 10, 12, 13, 14, 15};

    // Hand-computed tables pin the model itself.
    for (int k = 0; k < 12; k++) begin
      int a, b, t;
      butterfly(k, a, b, t);
      chk($sformatf("model A k=%0d", k), a, lit_a[k]);
      chk($sformatf("model B k=%0d", k), b, lit_b[k]);
      chk($sformatf("model Tw k=%0d", k), t, lit_tw[k]);
      chk($sformatf("model issue L2 k=%0d", k), issue_time(k, 2), lit_rd2[k]);
      chk($sformatf("model issue L1 k=%0d", k), issue_time(k, 1), lit_rd1[k]);
    end
    chk("model Done L2", run_len(2, 1'b0), 20);
    chk("model Done L1", run_len(1, 1'b0), 17);
    chk("model Done fault L2", run_len(2, 1'b1), 5);

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Start held high c0..c21: no restart mid-run, next run accepted the cycle after Done.
    done_q[0].delete(); done_q[1].delete();
    @(posedge clk); #1 start = 1'b1; c0 = cyc;
    repeat (22) @(posedge clk);
    #1 start = 1'b0;
    repeat (25) @(posedge clk);
    chk_done(0, c0, 2, 20, 41);
    chk_done(1, c0, 2, 17, 35);

    // Asynchronous reset in the middle of stage 1.
    @(posedge clk); #1 start = 1'b1; c0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("Rd_En before reset inst0", int'(rd_en[0]), 1);
    chk("Rd_En before reset inst1", int'(rd_en[1]), 1);
    #1 rstn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("Rd_En in reset inst%0d", i), int'(rd_en[i]), 0);
      chk($sformatf("Wr_En in reset inst%0d", i), int'(wr_en[i]), 0);
      chk($sformatf("Busy in reset inst%0d", i), int'(busy[i]), 0);
    end
    @(posedge clk);
    @(posedge clk); #1 rstn = 1'b1;
    done_q[0].delete(); done_q[1].delete();
    @(posedge clk); #1 start = 1'b1; c0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    repeat (25) @(posedge clk);
    chk_done(0, c0, 1, 20, 0);
    chk_done(1, c0, 1, 17, 0);

    // Counter zero flag stuck high at RUN entry.
    done_q[0].delete(); done_q[1].delete();
    @(posedge clk); #1 fault = 1'b1;
    @(posedge clk); #1 start = 1'b1; c0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    chk_done(0, c0, 1, 5, 0);
    chk_done(1, c0, 1, 4, 0);
    #1 fault = 1'b0;

    // Random Start traffic with occasional fault runs and mid-run resets.
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #1 start = ($urandom_range(0, 3) == 0);
      if (!m_active[0] && !m_active[1] && ($urandom_range(0, 7) == 0))
        fault = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
      end
    end
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
